neander_control: RTL and testbench

Control unit for the Neander CPU. It runs a multi-cycle Moore/Mealy FSM that sequences fetch, decode and execute by driving the datapath's load, increment and select strobes. It consumes the datapath's opcode and the registered N/Z flags.
- Instruction word (16 bits): [15:12] is the opcode and [7:0] is the operand address.
- Every instruction is a single word; there is no second operand fetch.

---
 rtl/neander_pkg.sv | 48 ++++
 rtl/neander_decode.sv | 29 ++
 rtl/neander_control.sv | 153 +++++++++++++++
 tb/tb_neander_control.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/neander_pkg.sv
// Shared types for the Neander CPU control path and datapath.
// Opcode, ULA operation, FSM state and instruction-class encodings.
// Pure type definitions, no logic.
package neander_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_STA = 4'h1,
    OP_LDA = 4'h2,
    OP_ADD = 4'h3,
    OP_OR  = 4'h4,
    OP_AND = 4'h5,
    OP_NOT = 4'h6,
    OP_JMP = 4'h8,
    OP_JN  = 4'h9,
    OP_JZ  = 4'hA,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ULA_ADD   = 3'b000,
    ULA_OR    = 3'b001,
    ULA_AND   = 3'b010,
    ULA_NOT   = 3'b011,
    ULA_PASSY = 3'b100
  } ula_op_t;

  typedef enum logic [2:0] {
    S_FETCH_REM,
    S_FETCH_RDM,
    S_DECODE,
    S_DISPATCH,
    S_MEM_RD,
    S_ALU,
    S_STORE,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MEM_ALU,
    CLS_STORE,
    CLS_UNARY,
    CLS_BRANCH,
    CLS_HALT
  } instr_class_t;

endpackage

// File: rtl/neander_decode.sv
// Opcode decoder: maps the RI opcode to an instruction class and ULA op.
// Purely combinational, zero latency.
// Undefined opcodes decode as NOP with the ADD operation selected.
module neander_decode
  import neander_pkg::*;
(
  input  logic [3:0]   opcode_i,
  output instr_class_t iclass_o,
  output ula_op_t      ula_op_o
);

  // Classify the opcode; the class drives the DISPATCH transition
  always_comb begin
    iclass_o = CLS_NOP;
    ula_op_o = ULA_ADD;
    case (opcode_i)
      OP_STA: iclass_o = CLS_STORE;
      OP_LDA: begin iclass_o = CLS_MEM_ALU; ula_op_o = ULA_PASSY; end
      OP_ADD: begin iclass_o = CLS_MEM_ALU; ula_op_o = ULA_ADD;   end
      OP_OR:  begin iclass_o = CLS_MEM_ALU; ula_op_o = ULA_OR;    end
      OP_AND: begin iclass_o = CLS_MEM_ALU; ula_op_o = ULA_AND;   end
      OP_NOT: begin iclass_o = CLS_UNARY;   ula_op_o = ULA_NOT;   end
      OP_JMP, OP_JN, OP_JZ: iclass_o = CLS_BRANCH;
      OP_HLT: iclass_o = CLS_HALT;
      default: iclass_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/neander_control.sv
// Neander control unit: multi-cycle fetch/decode/execute sequencer.
// Strobes are decoded combinationally from the registered state and opcode.
// run=0 freezes the FSM and blanks every strobe; rst blanks them too.
module neander_control
  import neander_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       n_in,
  input  logic       z_in,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       rem_load,
  output logic       sel_rem,
  output logic       rdm_load,
  output logic       ri_load,
  output logic       ac_load,
  output logic       n_load,
  output logic       z_load,
  output logic       mem_write,
  output logic [2:0] sel_ula,
  output logic       halted,
  output logic       instr_done
);

  state_t       state_q;
  logic         run_q;
  instr_class_t iclass;
  ula_op_t      dec_ula;
  ula_op_t      ula_sel;
  logic         strobe_en;
  logic         branch_taken;

  neander_decode u_decode (
    .opcode_i (opcode),
    .iclass_o (iclass),
    .ula_op_o (dec_ula)
  );

  // Strobes only fire while running and out of reset, so an in-flight
  // write cannot complete once rst is seen.
  assign strobe_en = run & ~rst;

  // Unconditional jump always loads PC; conditional ones follow the flags
  always_comb begin
    branch_taken = 1'b1;
    case (opcode)
      OP_JN:   branch_taken = n_in;
      OP_JZ:   branch_taken = z_in;
      default: branch_taken = 1'b1;
    endcase
  end

  // State register and transitions; run=0 holds the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH_REM;
      run_q   <= 1'b0;
    end else begin
      run_q <= run;
      if (run) begin
        case (state_q)
          S_FETCH_REM: state_q <= S_FETCH_RDM;
          S_FETCH_RDM: state_q <= S_DECODE;
          S_DECODE:    state_q <= S_DISPATCH;
          S_DISPATCH: begin
            case (iclass)
              CLS_MEM_ALU: state_q <= S_MEM_RD;
              CLS_STORE:   state_q <= S_STORE;
              CLS_HALT:    state_q <= S_HALT;
              default:     state_q <= S_FETCH_REM;
            endcase
          end
          S_MEM_RD:    state_q <= S_ALU;
          S_ALU:       state_q <= S_FETCH_REM;
          S_STORE:     state_q <= S_FETCH_REM;
          S_HALT: begin
            // A fresh run edge restarts fetch only in non-sticky builds
            if (!HALT_STICKY && !run_q) state_q <= S_FETCH_REM;
          end
          default:     state_q <= S_FETCH_REM;
        endcase
      end
    end
  end

  // Strobe decode from current state and opcode
  always_comb begin
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    rem_load   = 1'b0;
    sel_rem    = 1'b0;
    rdm_load   = 1'b0;
    ri_load    = 1'b0;
    ac_load    = 1'b0;
    n_load     = 1'b0;
    z_load     = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    ula_sel    = ULA_ADD;
    if (strobe_en) begin
      case (state_q)
        S_FETCH_REM: begin
          rem_load = 1'b1;
          sel_rem  = 1'b1;
        end
        S_FETCH_RDM: begin
          rdm_load = 1'b1;
          pc_inc   = 1'b1;
        end
        S_DECODE: ri_load = 1'b1;
        S_DISPATCH: begin
          case (iclass)
            CLS_MEM_ALU, CLS_STORE: rem_load = 1'b1;
            CLS_UNARY: begin
              ac_load    = 1'b1;
              n_load     = 1'b1;
              z_load     = 1'b1;
              ula_sel    = dec_ula;
              instr_done = 1'b1;
            end
            CLS_BRANCH: begin
              pc_load    = branch_taken;
              instr_done = 1'b1;
            end
            default: instr_done = 1'b1;
          endcase
        end
        S_MEM_RD: rdm_load = 1'b1;
        S_ALU: begin
          ac_load    = 1'b1;
          n_load     = 1'b1;
          z_load     = 1'b1;
          ula_sel    = dec_ula;
          instr_done = 1'b1;
        end
        S_STORE: begin
          mem_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sel_ula = ula_sel;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_neander_control.sv
// Directed bench for neander_control with a per-cycle expected-strobe queue.
module tb_neander_control;

  logic       clk = 1'b0;
  logic       rst, run;
  logic [3:0] opcode;
  logic       n_in, z_in;
  logic       pc_load, pc_inc, rem_load, sel_rem, rdm_load, ri_load;
  logic       ac_load, n_load, z_load, mem_write, halted, instr_done;
  logic [2:0] sel_ula;

  neander_control #(.HALT_STICKY(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .n_in(n_in), .z_in(z_in),
    .pc_load(pc_load), .pc_inc(pc_inc), .rem_load(rem_load), .sel_rem(sel_rem),
    .rdm_load(rdm_load), .ri_load(ri_load), .ac_load(ac_load), .n_load(n_load),
    .z_load(z_load), .mem_write(mem_write), .sel_ula(sel_ula), .halted(halted),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // Output vector: {pc_load,pc_inc,rem_load,sel_rem,rdm_load,ri_load,
  //                 ac_load,n_load,z_load,mem_write,sel_ula[2:0],halted,instr_done}
  logic [14:0] obs;
  assign obs = {pc_load, pc_inc, rem_load, sel_rem, rdm_load, ri_load,
                ac_load, n_load, z_load, mem_write, sel_ula, halted, instr_done};

  localparam logic [14:0] PCL  = 15'h4000;
  localparam logic [14:0] PCI  = 15'h2000;
  localparam logic [14:0] REM  = 15'h1000;
  localparam logic [14:0] SRM  = 15'h0800;
  localparam logic [14:0] RDM  = 15'h0400;
  localparam logic [14:0] RIL  = 15'h0200;
  localparam logic [14:0] FLG  = 15'h01C0;
  localparam logic [14:0] MW   = 15'h0020;
  localparam logic [14:0] HLTD = 15'h0002;
  localparam logic [14:0] DONE = 15'h0001;

  logic [14:0] exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  string tag      = "init";

  function automatic logic [14:0] ula(input logic [2:0] u);
    return {10'b0, u, 2'b00};
  endfunction

  // Compare on the falling edge, then advance to just after the next rising edge
  task automatic drain();
    logic [14:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_fetch();
    exp_q.push_back(REM | SRM);
    exp_q.push_back(RDM | PCI);
    exp_q.push_back(RIL);
  endtask

  task automatic push_tail(input logic [3:0] op, input logic n, input logic z);
    case (op)
      4'h1: begin exp_q.push_back(REM); exp_q.push_back(MW | DONE); end
      4'h2: begin exp_q.push_back(REM); exp_q.push_back(RDM); exp_q.push_back(FLG | ula(3'd4) | DONE); end
      4'h3: begin exp_q.push_back(REM); exp_q.push_back(RDM); exp_q.push_back(FLG | ula(3'd0) | DONE); end
      4'h4: begin exp_q.push_back(REM); exp_q.push_back(RDM); exp_q.push_back(FLG | ula(3'd1) | DONE); end
      4'h5: begin exp_q.push_back(REM); exp_q.push_back(RDM); exp_q.push_back(FLG | ula(3'd2) | DONE); end
      4'h6: exp_q.push_back(FLG | ula(3'd3) | DONE);
      4'h8: exp_q.push_back(PCL | DONE);
      4'h9: exp_q.push_back((n ? PCL : 15'h0) | DONE);
      4'hA: exp_q.push_back((z ? PCL : 15'h0) | DONE);
      4'hF: exp_q.push_back(DONE);
      default: exp_q.push_back(DONE);
    endcase
  endtask

  task automatic do_instr(input string name, input logic [3:0] op,
                          input logic n, input logic z);
    tag = name; opcode = op; n_in = n; z_in = z;
    push_fetch();
    push_tail(op, n, z);
    drain();
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b1; opcode = 4'h0; n_in = 1'b0; z_in = 1'b0;
    #2;
    tag = "reset";
    exp_q.push_back(15'h0);
    exp_q.push_back(15'h0);
    drain();
    rst = 1'b0;

    do_instr("nop0",  4'h0, 1'b0, 1'b0);
    do_instr("nop1",  4'h0, 1'b0, 1'b0);
    do_instr("add",   4'h3, 1'b0, 1'b0);
    do_instr("or",    4'h4, 1'b0, 1'b0);
    do_instr("and",   4'h5, 1'b0, 1'b0);
    do_instr("lda",   4'h2, 1'b0, 1'b0);
    do_instr("not",   4'h6, 1'b0, 1'b0);
    do_instr("jmp",   4'h8, 1'b0, 1'b0);
    do_instr("jn_t",  4'h9, 1'b1, 1'b0);
    do_instr("jn_nt", 4'h9, 1'b0, 1'b1);
    do_instr("jz_t",  4'hA, 1'b0, 1'b1);
    do_instr("jz_nt", 4'hA, 1'b1, 1'b0);
    do_instr("sta",   4'h1, 1'b0, 1'b0);
    do_instr("undef7", 4'h7, 1'b0, 1'b0);
    do_instr("undefC", 4'hC, 1'b1, 1'b1);

    // Freeze for three cycles while in MEM_RD
    tag = "freeze"; opcode = 4'h3;
    push_fetch(); exp_q.push_back(REM);
    drain();
    run = 1'b0;
    repeat (3) exp_q.push_back(15'h0);
    drain();
    run = 1'b1;
    tag = "thaw";
    exp_q.push_back(RDM);
    exp_q.push_back(FLG | ula(3'd0) | DONE);
    drain();

    // Reset landing on the ALU cycle of LDA
    tag = "rst_alu"; opcode = 4'h2;
    push_fetch(); exp_q.push_back(REM); exp_q.push_back(RDM);
    drain();
    rst = 1'b1;
    exp_q.push_back(15'h0); exp_q.push_back(15'h0);
    drain();
    rst = 1'b0;
    do_instr("refetch_alu", 4'h0, 1'b0, 1'b0);

    // Reset landing on the STORE cycle of STA
    tag = "rst_store"; opcode = 4'h1;
    push_fetch(); exp_q.push_back(REM);
    drain();
    rst = 1'b1;
    exp_q.push_back(15'h0);
    drain();
    rst = 1'b0;
    do_instr("refetch_sta", 4'h1, 1'b0, 1'b0);

    // Halt: sticky against run toggles, left only by reset
    tag = "hlt"; opcode = 4'hF;
    push_fetch(); exp_q.push_back(DONE);
    repeat (20) exp_q.push_back(HLTD);
    drain();
    tag = "hlt_run";
    run = 1'b0; repeat (3) exp_q.push_back(HLTD); drain();
    run = 1'b1; repeat (3) exp_q.push_back(HLTD); drain();
    run = 1'b0; repeat (2) exp_q.push_back(HLTD); drain();
    run = 1'b1; repeat (2) exp_q.push_back(HLTD); drain();
    tag = "hlt_rst";
    rst = 1'b1;
    exp_q.push_back(15'h0);
    drain();
    rst = 1'b0;
    do_instr("after_hlt", 4'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
